resource_response_router: RTL and testbench
===========================================

// Module: resource_response_router
// PURPOSE
//  Return path from the shared resource to the two pipelines. Takes the single
//  result bus plus its one-hot owner valid and buffers each result in a per-pipeline
//  response FIFO. Each FIFO drains to its pipeline over a valid/ready handshake.
//  Tracks in-flight requests per pipeline, issues credit stalls so a FIFO never
//  overflows, and discards stale responses after a pipeline flush.
// PARAMETERS
//  DATA_W  32  result/data width
//  DEPTH   4   entries per response FIFO (power of 2, >=2)
//  CNT_W   $clog2(DEPTH)+1  derived width of occupancy/in-flight/drop counters
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  rsp_data     in   DATA_W  result from shared resource
//  rsp_valid    in   2       one-hot owner: [0]=pipeline 1, [1]=pipeline 2
//  issue        in   2       request accepted into resource this cycle, per pipeline
//  flush        in   2       per-pipeline flush, 1-cycle pulse
//  out_data_1   out  DATA_W  FIFO-1 head
//  out_valid_1  out  1       FIFO-1 non-empty
//  out_ready_1  in   1       pipeline 1 consumes head
//  out_data_2   out  DATA_W  FIFO-2 head
//  out_valid_2  out  1       FIFO-2 non-empty
//  out_ready_2  in   1       pipeline 2 consumes head
//  stall        out  2       credit stall per pipeline, toward arbiter request gating
//  err          out  1       sticky protocol error
// BEHAVIOUR
//  Reset: all FIFOs empty, all counters 0.
//   out_valid_*=0, out_data_*=0, stall=0, err=0.
//  Per pipeline i: occ_i = FIFO entries; infl_i = issued, not yet returned;
//   drop_i = oldest in-flight responses to discard (drop_i<=infl_i always).
//  Resource is in-order per pipeline.
//  Issue: issue[i] -> infl_i+1 at next edge.
//  Arrival (rsp_valid[i]=1): infl_i-1.
//   If drop_i>0: drop_i-1, data discarded.
//   Else: data written to FIFO tail.
//  Latency: written entry sets out_valid_i the following cycle.
//   No bypass; min rsp->out latency = 1 clk.
//  Drain: pop on out_valid_i & out_ready_i.
//   out_data_i held stable while out_valid_i & !out_ready_i.
//  Simultaneous push+pop: allowed at any occupancy incl. full; occ unchanged.
//   When occ=1 and both occur, the new entry is visible next cycle.
//  Credit: stall[i] = (occ_i + infl_i >= DEPTH).
//   Combinational from registers only; no dependence on same-cycle inputs.
//  Simultaneous issue+arrival: infl_i unchanged.
//  Flush[i]:
//   - FIFO i emptied at next edge; a pop in the same cycle is ignored.
//   - An arrival in the same cycle is discarded.
//   - drop_i <= infl_i minus 1 if an arrival occurs this cycle.
//     Issues in the flush cycle are new requests, not dropped.
//   - The other pipeline is unaffected.
//  Errors, each sets err until reset. The offending data is dropped; no other state changes.
//   - rsp_valid==2'b11: neither FIFO written.
//   - arrival with infl_i==0.
//   - write into a full FIFO without a same-cycle pop.
//   - issue[i] while stall[i]=1.
//     Counters still update; saturate at 2^CNT_W-1.
//  Reset mid-operation: asynchronous clear of all state.
//   Responses arriving after reset are errors (infl=0).
// TESTING
//  1. Issue 2 to p1; rsp_valid=01 with A1, A2 on later cycles; out_ready_1=1.
//     -> out_valid_1 one cycle after each arrival, data A1 then A2; infl_1=0.
//  2. DEPTH=4, out_ready_1=0, issue 4 to p1.
//     -> stall[0]=1 after 4th issue.
//     Return all 4 -> occ_1=4, stall[0] stays 1.
//     One pop -> stall[0]=0.
//  3. Issue 3 to p2; flush[1] with 1 already buffered and 2 in flight.
//     -> FIFO-2 empty and drop_2=2.
//     Next 2 arrivals discarded; 3rd new issue's result delivered; err=0.
//  4. Interleave rsp_valid=01/10 every cycle; both readies toggle pseudo-randomly.
//     -> each pipeline sees exactly its own data in order; no loss/duplication.
//  5. rsp_valid=11, then arrival with infl=0, then issue while stalled.
//     -> err=1 after the first and stays 1; FIFOs unchanged by the bad arrivals.
//  6. Assert reset low mid-burst with FIFOs half full.
//     -> out_valid_*=0, stall=0, err=0 immediately.
//     After release, a fresh issue/response completes.

Source files
------------

// File: rtl/resource_response_router.sv
// -----------------------------------------------------------------------------
// resource_response_router
//   Return path from the shared resource to two pipelines. Each result on the
//   shared bus is routed by its one-hot owner valid into a per-pipeline response
//   FIFO that drains over a valid/ready handshake. The block tracks in-flight
//   requests per pipeline, raises credit stalls so a FIFO can never overflow,
//   and discards responses to requests that were outstanding at a flush.
//
// Ports
//   clk, reset             clock (rising edge), asynchronous active-low reset
//   rsp_data / rsp_valid   result bus and one-hot owner ([0]=p1, [1]=p2)
//   issue                  request accepted by the resource this cycle
//   flush                  per-pipeline flush pulse
//   out_data_N/out_valid_N FIFO-N head and non-empty flag
//   out_ready_N            pipeline N consumes the head
//   stall                  credit stall per pipeline (registers only)
//   err                    sticky protocol error
// -----------------------------------------------------------------------------
module resource_response_router #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic [1:0]        rsp_valid,
  input  logic [1:0]        issue,
  input  logic [1:0]        flush,
  output logic [DATA_W-1:0] out_data_1,
  output logic              out_valid_1,
  input  logic              out_ready_1,
  output logic [DATA_W-1:0] out_data_2,
  output logic              out_valid_2,
  input  logic              out_ready_2,
  output logic [1:0]        stall,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] mem_q [2][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [2], wr_ptr_d [2];
  logic [PTR_W-1:0]  rd_ptr_q [2], rd_ptr_d [2];
  logic [CNT_W-1:0]  occ_q [2], occ_d [2];
  logic [CNT_W-1:0]  infl_q [2], infl_d [2];
  logic [CNT_W-1:0]  drop_q [2], drop_d [2];
  logic              err_q, err_d;

  logic [1:0]        out_ready, out_valid, pop, taken, push;
  logic [DATA_W-1:0] head [2];
  logic              both_valid;

  assign out_ready  = {out_ready_2, out_ready_1};
  assign both_valid = (rsp_valid == 2'b11);

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    err_d     = err_q | both_valid;
    out_valid = '0;
    pop       = '0;
    taken     = '0;
    push      = '0;
    stall     = '0;
    for (int i = 0; i < 2; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      occ_d[i]    = occ_q[i];
      infl_d[i]   = infl_q[i];
      drop_d[i]   = drop_q[i];

      stall[i]     = ({1'b0, occ_q[i]} + {1'b0, infl_q[i]}) >= (CNT_W+1)'(DEPTH);
      out_valid[i] = (occ_q[i] != '0);
      // Gate the head so an empty FIFO presents zero, whatever the storage holds.
      head[i]      = out_valid[i] ? mem_q[i][rd_ptr_q[i]] : '0;
      pop[i]       = out_valid[i] & out_ready[i] & ~flush[i];

      // A bad arrival (both owners, or nothing outstanding) is dropped without
      // touching the counters; a good one always retires one in-flight request.
      if (rsp_valid[i] && !both_valid) begin
        if (infl_q[i] == '0) begin
          err_d = 1'b1;
        end else if (flush[i]) begin
          taken[i] = 1'b1;
        end else if (drop_q[i] != '0) begin
          taken[i]  = 1'b1;
          drop_d[i] = drop_q[i] - CNT_W'(1);
        end else if (occ_q[i] == CNT_W'(DEPTH) && !pop[i]) begin
          err_d = 1'b1;
        end else begin
          taken[i] = 1'b1;
          push[i]  = 1'b1;
        end
      end

      if (issue[i] && stall[i]) err_d = 1'b1;

      unique case ({issue[i], taken[i]})
        2'b10:   infl_d[i] = (infl_q[i] == CNT_MAX) ? infl_q[i] : infl_q[i] + CNT_W'(1);
        2'b01:   infl_d[i] = infl_q[i] - CNT_W'(1);
        default: infl_d[i] = infl_q[i];
      endcase

      if (flush[i]) begin
        // Everything outstanding before this cycle becomes stale; an arrival
        // retired in this same cycle is no longer outstanding.
        drop_d[i]   = infl_q[i] - CNT_W'(taken[i]);
        occ_d[i]    = '0;
        rd_ptr_d[i] = wr_ptr_q[i];
      end else begin
        if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
        if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
        unique case ({push[i], pop[i]})
          2'b10:   occ_d[i] = occ_q[i] + CNT_W'(1);
          2'b01:   occ_d[i] = occ_q[i] - CNT_W'(1);
          default: occ_d[i] = occ_q[i];
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        occ_q[i]    <= '0;
        infl_q[i]   <= '0;
        drop_q[i]   <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        occ_q[i]    <= occ_d[i];
        infl_q[i]   <= infl_d[i];
        drop_q[i]   <= drop_d[i];
      end
      err_q <= err_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy decides what is valid and
  // the head mux hides stale contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= rsp_data;
    end
  end

  assign out_data_1  = head[0];
  assign out_data_2  = head[1];
  assign out_valid_1 = out_valid[0];
  assign out_valid_2 = out_valid[1];
  assign err         = err_q;

endmodule

// File: tb/tb_resource_response_router.sv
// -----------------------------------------------------------------------------
// tb_resource_response_router
//   Self-checking bench: directed scenarios plus randomized traffic, compared
//   every cycle against a queue-based reference model of the router.
// -----------------------------------------------------------------------------
module tb_resource_response_router;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_valid, issue, flush, stall;
  logic [DATA_W-1:0] out_data_1, out_data_2;
  logic              out_valid_1, out_valid_2, out_ready_1, out_ready_2, err;

  resource_response_router #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .issue(issue), .flush(flush),
    .out_data_1(out_data_1), .out_valid_1(out_valid_1), .out_ready_1(out_ready_1),
    .out_data_2(out_data_2), .out_valid_2(out_valid_2), .out_ready_2(out_ready_2),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one queue of pending responses per pipeline, plus plain
  // integer counts of outstanding and to-be-discarded requests.
  logic [DATA_W-1:0] mq [2][$];
  int                m_infl [2];
  int                m_drop [2];
  bit                m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_stall(input int i);
    return (mq[i].size() + m_infl[i]) >= DEPTH;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_infl[i] = 0;
      m_drop[i] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic check_outputs();
    check("out_valid_1", 64'(out_valid_1), 64'(mq[0].size() > 0));
    check("out_data_1",  64'(out_data_1),  64'((mq[0].size() > 0) ? mq[0][0] : '0));
    check("out_valid_2", 64'(out_valid_2), 64'(mq[1].size() > 0));
    check("out_data_2",  64'(out_data_2),  64'((mq[1].size() > 0) ? mq[1][0] : '0));
    check("stall",       64'(stall),       64'({m_stall(1), m_stall(0)}));
    check("err",         64'(err),         64'(m_err));
  endtask

  task automatic model_step(input logic [1:0] iss, input logic [1:0] rv,
                            input logic [1:0] fl, input logic [1:0] rdy,
                            input logic [DATA_W-1:0] d);
    bit both;
    bit [1:0] st;
    both = (rv == 2'b11);
    st   = {m_stall(1), m_stall(0)};
    if (both) m_err = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bit pop;
      bit push;
      int taken;
      pop   = (mq[i].size() > 0) && rdy[i] && !fl[i];
      push  = 1'b0;
      taken = 0;
      if (rv[i] && !both) begin
        if (m_infl[i] == 0)                          m_err = 1'b1;
        else if (fl[i])                              taken = 1;
        else if (m_drop[i] > 0) begin                m_drop[i]--; taken = 1; end
        else if (mq[i].size() == DEPTH && !pop)      m_err = 1'b1;
        else begin                                   taken = 1; push = 1'b1; end
      end
      if (iss[i] && st[i]) m_err = 1'b1;
      if (fl[i]) begin
        m_drop[i] = m_infl[i] - taken;
        mq[i].delete();
      end else begin
        if (pop)  void'(mq[i].pop_front());
        if (push) mq[i].push_back(d);
      end
      m_infl[i] = m_infl[i] - taken + int'(iss[i]);
      if (m_infl[i] > CNT_MAX) m_infl[i] = CNT_MAX;
    end
  endtask

  // One clock: check registered outputs mid-cycle, drive this cycle's inputs,
  // advance the model, then let the DUT take the edge.
  task automatic cycle(input logic [1:0] iss, input logic [1:0] rv, input logic [1:0] fl,
                       input logic [1:0] rdy, input logic [DATA_W-1:0] d);
    @(negedge clk);
    check_outputs();
    issue       = iss;
    rsp_valid   = rv;
    flush       = fl;
    out_ready_1 = rdy[0];
    out_ready_2 = rdy[1];
    rsp_data    = d;
    model_step(iss, rv, fl, rdy, d);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    issue = '0; rsp_valid = '0; flush = '0;
    reset = 1'b1;
  endtask

  task automatic random_cycle(input bit allow_err);
    logic [1:0] iss, rv, fl, rdy;
    int r;
    iss = '0; rv = '0; fl = '0;
    for (int i = 0; i < 2; i++) begin
      if ((allow_err || !m_stall(i)) && ($urandom % 3 == 0)) iss[i] = 1'b1;
      if ($urandom % 25 == 0) fl[i] = 1'b1;
    end
    r = int'($urandom % 4);
    if (r < 2 && (allow_err || m_infl[r] > 0)) rv[r] = 1'b1;
    if (allow_err && ($urandom % 12 == 0)) rv = 2'b11;
    rdy = 2'($urandom);
    cycle(iss, rv, fl, rdy, $urandom);
  endtask

  initial begin
    reset = 1'b0;
    issue = '0; rsp_valid = '0; flush = '0;
    out_ready_1 = 1'b0; out_ready_2 = 1'b0; rsp_data = '0;
    model_reset();
    do_reset();

    // In-order delivery to pipeline 1 with one-cycle latency.
    cycle(2'b01, 2'b00, 2'b00, 2'b11, 32'h0);
    cycle(2'b01, 2'b00, 2'b00, 2'b11, 32'h0);
    cycle(2'b00, 2'b01, 2'b00, 2'b11, 32'hA1A1_0001);
    cycle(2'b00, 2'b00, 2'b00, 2'b11, 32'h0);
    cycle(2'b00, 2'b01, 2'b00, 2'b11, 32'hA2A2_0002);
    cycle(2'b00, 2'b00, 2'b00, 2'b11, 32'h0);
    cycle(2'b00, 2'b00, 2'b00, 2'b11, 32'h0);

    // Credit stall at DEPTH outstanding, held while full, released by a pop.
    for (int k = 0; k < DEPTH; k++) cycle(2'b01, 2'b00, 2'b00, 2'b00, 32'h0);
    for (int k = 0; k < DEPTH; k++) cycle(2'b00, 2'b01, 2'b00, 2'b00, 32'hB000 + k);
    cycle(2'b00, 2'b00, 2'b00, 2'b00, 32'h0);
    cycle(2'b00, 2'b00, 2'b00, 2'b01, 32'h0);
    cycle(2'b00, 2'b00, 2'b00, 2'b00, 32'h0);
    // Full FIFO with simultaneous push and pop.
    cycle(2'b01, 2'b00, 2'b00, 2'b00, 32'h0);
    cycle(2'b00, 2'b01, 2'b00, 2'b01, 32'hB0B0);
    for (int k = 0; k < DEPTH + 1; k++) cycle(2'b00, 2'b00, 2'b00, 2'b01, 32'h0);

    // Flush of pipeline 2 with one buffered and two in flight.
    for (int k = 0; k < 3; k++) cycle(2'b10, 2'b00, 2'b00, 2'b00, 32'h0);
    cycle(2'b00, 2'b10, 2'b00, 2'b00, 32'hC001);
    cycle(2'b00, 2'b00, 2'b10, 2'b00, 32'h0);
    cycle(2'b10, 2'b10, 2'b00, 2'b10, 32'hC002);
    cycle(2'b00, 2'b10, 2'b00, 2'b10, 32'hC003);
    cycle(2'b00, 2'b10, 2'b00, 2'b10, 32'hC004);
    cycle(2'b00, 2'b00, 2'b00, 2'b10, 32'h0);
    cycle(2'b00, 2'b00, 2'b00, 2'b10, 32'h0);

    // Legal randomized traffic on both pipelines; err must stay clear.
    for (int k = 0; k < 2000; k++) random_cycle(1'b0);

    // Protocol errors: both owners, arrival with nothing outstanding, issue while stalled.
    for (int k = 0; k < 6; k++) cycle(2'b00, 2'b00, 2'b00, 2'b11, 32'h0);
    cycle(2'b01, 2'b00, 2'b00, 2'b00, 32'h0);
    cycle(2'b00, 2'b11, 2'b00, 2'b00, 32'hE001);
    cycle(2'b00, 2'b10, 2'b00, 2'b00, 32'hE002);
    for (int k = 0; k < DEPTH; k++) cycle(2'b01, 2'b00, 2'b00, 2'b00, 32'h0);
    cycle(2'b00, 2'b00, 2'b00, 2'b00, 32'h0);

    // Reset mid-burst, then a fresh transaction.
    do_reset();
    cycle(2'b10, 2'b00, 2'b00, 2'b11, 32'h0);
    cycle(2'b00, 2'b10, 2'b00, 2'b11, 32'hF00D);
    cycle(2'b00, 2'b00, 2'b00, 2'b11, 32'h0);
    cycle(2'b00, 2'b00, 2'b00, 2'b11, 32'h0);

    // Randomized traffic including protocol errors, with a reset in the middle.
    for (int k = 0; k < 600; k++) random_cycle(1'b1);
    do_reset();
    for (int k = 0; k < 600; k++) random_cycle(1'b0);

    @(negedge clk);
    check_outputs();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
